// File: rtl/display_source_sequencer_pkg.sv
// Shared constants for the display source sequencer: active-low hex glyphs,
// the blank pattern, the sequencer state type and a width helper.
package display_source_sequencer_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } seq_state_e;

    // Ceiling log2, never narrower than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/display_source_sequencer_seg7_hex_decode.sv
// Combinational hex digit to active-low 7-segment glyph.
module seg7_hex_decode
    import display_source_sequencer_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_HEX[hex_i];

endmodule

// File: rtl/display_source_sequencer.sv
// Selects one of NUM_SRC digit sources (load / step / timed rotation) and
// drives NUM_DIGITS registered active-low 7-segment displays.
module display_source_sequencer
    import display_source_sequencer_pkg::*;
#(
    parameter  int NUM_SRC      = 2,
    parameter  int NUM_DIGITS   = 4,
    parameter  int DWELL_CYCLES = 50000000,
    parameter  int BLANK_LZ     = 1,
    localparam int SELW         = clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_SRC*NUM_DIGITS*4-1:0] src_digits,
    input  logic                          auto_en,
    input  logic                          step,
    input  logic                          sel_load,
    input  logic [SELW-1:0]               sel_value,
    output logic [NUM_DIGITS*7-1:0]       seg,
    output logic [SELW-1:0]               cur_src,
    output logic                          src_change
);

    localparam int              CNTW      = clog2(DWELL_CYCLES);
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(DWELL_CYCLES - 1);
    localparam logic [SELW-1:0] SEL_LAST  = SELW'(NUM_SRC - 1);
    localparam logic [SELW:0]   SRC_LIMIT = (SELW + 1)'(NUM_SRC);

    seq_state_e              state_q, state_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [SELW-1:0]         cur_src_q, cur_src_d;
    logic                    src_change_q;
    logic [NUM_DIGITS*7-1:0] seg_q, seg_d;

    logic                    load_ok;
    logic                    expire;
    logic [SELW-1:0]         next_sel;

    assign load_ok  = sel_load && ({1'b0, sel_value} < SRC_LIMIT);
    assign next_sel = (cur_src_q == SEL_LAST) ? '0 : cur_src_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_src_d = cur_src_q;
        expire    = 1'b0;

        if (state_q == ST_MANUAL) begin
            cnt_d = '0;
            if (auto_en) begin
                state_d = ST_AUTO;
            end
        end else begin
            // Leaving AUTO on an expiry cycle suppresses the advance.
            if (!auto_en) begin
                state_d = ST_MANUAL;
                cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                expire = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (load_ok) begin
            cur_src_d = sel_value;
            cnt_d     = '0;
        end else if (step) begin
            cur_src_d = next_sel;
            cnt_d     = '0;
        end else if (expire) begin
            cur_src_d = next_sel;
        end
    end

    // Digit datapath: pick the current source, decode and blank.
    logic [NUM_DIGITS*4-1:0] src_arr [NUM_SRC];
    logic [NUM_DIGITS*4-1:0] sel_digits;
    logic [NUM_DIGITS*7-1:0] dec_seg;
    logic [NUM_DIGITS:1]     zero_from;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_arr[gi] = src_digits[gi*NUM_DIGITS*4 +: NUM_DIGITS*4];
        end
    endgenerate

    assign sel_digits            = src_arr[cur_src_q];
    assign zero_from[NUM_DIGITS] = 1'b1;

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            seg7_hex_decode u_dec (
                .hex_i (sel_digits[gi*4 +: 4]),
                .seg_o (dec_seg[gi*7 +: 7])
            );
            if (gi == 0) begin : g_lsd
                assign seg_d[6:0] = dec_seg[6:0];
            end else begin : g_upper
                // zero_from[d]: digit d and everything above it are zero.
                if (gi < NUM_DIGITS - 1) begin : g_chain
                    assign zero_from[gi] = (sel_digits[gi*4 +: 4] == 4'h0) && zero_from[gi+1];
                end else begin : g_top
                    assign zero_from[gi] = (sel_digits[gi*4 +: 4] == 4'h0);
                end
                assign seg_d[gi*7 +: 7] = ((BLANK_LZ != 0) && zero_from[gi]) ? SEG_BLANK
                                                                            : dec_seg[gi*7 +: 7];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_MANUAL;
            cnt_q        <= '0;
            cur_src_q    <= '0;
            src_change_q <= 1'b0;
            seg_q        <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_src_q    <= cur_src_d;
            src_change_q <= (cur_src_d != cur_src_q);
            seg_q        <= seg_d;
        end
    end

    assign seg        = seg_q;
    assign cur_src    = cur_src_q;
    assign src_change = src_change_q;

endmodule

// File: tb/tb_display_source_sequencer.sv
// Scoreboard bench: a cycle reference model pushes expected outputs, a monitor
// on the falling edge pops and compares both a blanking and a non-blanking DUT.
module tb_display_source_sequencer;

    localparam int NS = 3;
    localparam int ND = 4;
    localparam int DW = 4;

    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [NS*ND*4-1:0] src_digits = '0;
    logic              auto_en = 1'b0;
    logic              step = 1'b0;
    logic              sel_load = 1'b0;
    logic [1:0]        sel_value = 2'd0;

    logic [ND*7-1:0]   seg_a, seg_b;
    logic [1:0]        cur_a, cur_b;
    logic              chg_a, chg_b;

    always #5 clk = ~clk;

    display_source_sequencer #(.NUM_SRC(NS), .NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_LZ(1)) dut_lz (
        .clk(clk), .reset_n(reset_n), .src_digits(src_digits), .auto_en(auto_en),
        .step(step), .sel_load(sel_load), .sel_value(sel_value),
        .seg(seg_a), .cur_src(cur_a), .src_change(chg_a)
    );

    display_source_sequencer #(.NUM_SRC(NS), .NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_LZ(0)) dut_nz (
        .clk(clk), .reset_n(reset_n), .src_digits(src_digits), .auto_en(auto_en),
        .step(step), .sel_load(sel_load), .sel_value(sel_value),
        .seg(seg_b), .cur_src(cur_b), .src_change(chg_b)
    );

    typedef struct packed {
        logic [1:0]      cur;
        logic            chg;
        logic [ND*7-1:0] seg_lz;
        logic [ND*7-1:0] seg_nz;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   m_src = 0;
    int   m_cnt = 0;
    bit   m_auto = 1'b0;

    // Displayed value of source s, with optional leading-zero suppression.
    function automatic logic [ND*7-1:0] render(input int s, input bit lz, input logic [NS*ND*4-1:0] digs);
        logic [15:0]     val;
        logic [ND*7-1:0] r;
        val = digs[s*16 +: 16];
        for (int d = 0; d < ND; d++) begin
            if (lz && d > 0 && (val >> (4*d)) == 16'd0)
                r[d*7 +: 7] = 7'h7F;
            else
                r[d*7 +: 7] = HEX7[val[d*4 +: 4]];
        end
        return r;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.cur    = 2'd0;
        e.chg    = 1'b0;
        e.seg_lz = '1;
        e.seg_nz = '1;
        return e;
    endfunction

    // Reference model: one expected output set per rising edge.
    always @(posedge clk) begin
        exp_t e;
        int   prev;
        if (!reset_n) begin
            m_src  = 0;
            m_cnt  = 0;
            m_auto = 1'b0;
            exp_q.push_back(reset_exp());
        end else begin
            prev     = m_src;
            e.seg_lz = render(prev, 1'b1, src_digits);
            e.seg_nz = render(prev, 1'b0, src_digits);
            if (sel_load && int'(sel_value) < NS) begin
                m_src = int'(sel_value);
                m_cnt = 0;
            end else if (step) begin
                m_src = (m_src + 1) % NS;
                m_cnt = 0;
            end else if (m_auto && auto_en) begin
                if (m_cnt == DW - 1) begin
                    m_cnt = 0;
                    m_src = (m_src + 1) % NS;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_cnt = 0;
            end
            m_auto = auto_en;
            e.cur  = 2'(m_src);
            e.chg  = (m_src != prev);
            exp_q.push_back(e);
        end
    end

    // Asynchronous reset takes effect before the next edge's outputs are seen.
    always @(negedge reset_n) begin
        m_src  = 0;
        m_cnt  = 0;
        m_auto = 1'b0;
        if (exp_q.size() > 0) exp_q[$] = reset_exp();
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (cur_a !== e.cur) begin
                miscompares++;
                $display("FAIL cur_src_lz t=%0t got %0d expected %0d", $time, cur_a, e.cur);
            end
            if (cur_b !== e.cur) begin
                miscompares++;
                $display("FAIL cur_src_nz t=%0t got %0d expected %0d", $time, cur_b, e.cur);
            end
            if (chg_a !== e.chg || chg_b !== e.chg) begin
                miscompares++;
                $display("FAIL src_change t=%0t got %b/%b expected %b", $time, chg_a, chg_b, e.chg);
            end
            if (seg_a !== e.seg_lz) begin
                miscompares++;
                $display("FAIL seg_blank t=%0t got %h expected %h", $time, seg_a, e.seg_lz);
            end
            if (seg_b !== e.seg_nz) begin
                miscompares++;
                $display("FAIL seg_full t=%0t got %h expected %h", $time, seg_b, e.seg_nz);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_step();
        step = 1'b1;
        cyc(1);
        step = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] v);
        sel_load  = 1'b1;
        sel_value = v;
        cyc(1);
        sel_load  = 1'b0;
    endtask

    function automatic logic [NS*ND*4-1:0] rand_digits();
        logic [NS*ND*4-1:0] r;
        for (int i = 0; i < NS*ND; i++)
            r[i*4 +: 4] = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'h0;
        return r;
    endfunction

    initial begin
        #1 reset_n = 1'b0;
        src_digits = {16'h1234, 16'h00A0, 16'h0012};
        cyc(3);
        reset_n = 1'b1;
        cyc(3);

        repeat (3) begin
            do_step();
            cyc(2);
        end

        do_load(2'd3);
        cyc(2);
        do_load(2'd2);
        cyc(2);
        do_load(2'd2);
        cyc(2);

        do_load(2'd0);
        auto_en = 1'b1;
        cyc(6);
        do_step();
        cyc(9);

        auto_en = 1'b0;
        do_load(2'd0);
        cyc(1);
        sel_load  = 1'b1;
        sel_value = 2'd1;
        step      = 1'b1;
        cyc(1);
        sel_load  = 1'b0;
        step      = 1'b0;
        cyc(2);

        do_load(2'd0);
        auto_en = 1'b1;
        cyc(4);
        auto_en = 1'b0;
        cyc(3);

        do_load(2'd1);
        auto_en = 1'b1;
        cyc(5);
        reset_n = 1'b0;
        cyc(2);
        auto_en = 1'b0;
        reset_n = 1'b1;
        cyc(2);

        for (int i = 0; i < 3000; i++) begin
            step      = ($urandom_range(7) == 0);
            sel_load  = ($urandom_range(9) == 0);
            sel_value = 2'($urandom_range(3));
            if ($urandom_range(40) == 0) auto_en = ~auto_en;
            if ($urandom_range(15) == 0) src_digits = rand_digits();
            reset_n = ($urandom_range(400) != 0);
            cyc(1);
        end
        step     = 1'b0;
        sel_load = 1'b0;
        reset_n  = 1'b1;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
